// File: rtl/game_pkg.sv
// Shared encodings and default sizing for the falling-character game engine.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int CHAR_W          = 8;
  localparam int SCORE_W         = 8;
  localparam int LIVES_W         = 4;
  localparam int NUM_LANES_DEF   = 8;
  localparam int POS_W_DEF       = 10;
  localparam int SPEED_W_DEF     = 3;
  localparam int LOWER_BOUND_DEF = 480;
  localparam int LIVES_DEF       = 3;

endpackage

// File: rtl/lane_select.sv
// Priority selector: among flagged lanes pick the largest pos, lowest index on ties.
module lane_select #(
  parameter int N     = 8,
  parameter int POS_W = 10
) (
  input  logic [N-1:0]            cand,
  input  logic [N-1:0][POS_W-1:0] pos,
  output logic [$clog2(N)-1:0]    idx,
  output logic                    found
);

  logic [POS_W-1:0] best;

  // Strict '>' keeps the earlier (lower) index when positions tie.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    best  = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && (!found || pos[i] > best)) begin
        idx   = ($clog2(N))'(i);
        found = 1'b1;
        best  = pos[i];
      end
    end
  end

endmodule

// File: rtl/char_lane_engine.sv
// Falling-character game core: lane table, key matching, frame advance,
// lives/score bookkeeping and a registered renderer read port.
module char_lane_engine
  import game_pkg::*;
#(
  parameter int NUM_LANES   = NUM_LANES_DEF,
  parameter int POS_W       = POS_W_DEF,
  parameter int SPEED_W     = SPEED_W_DEF,
  parameter int LOWER_BOUND = LOWER_BOUND_DEF,
  parameter int LIVES       = LIVES_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         tick,
  input  logic                         spawn_valid,
  output logic                         spawn_ready,
  input  logic [CHAR_W-1:0]            spawn_char,
  input  logic [SPEED_W-1:0]           spawn_speed,
  input  logic                         key_valid,
  input  logic [CHAR_W-1:0]            key_code,
  input  logic [$clog2(NUM_LANES)-1:0] rd_lane,
  output logic                         rd_active,
  output logic [CHAR_W-1:0]            rd_char,
  output logic [POS_W-1:0]             rd_pos,
  output logic [1:0]                   state,
  output logic [SCORE_W-1:0]           score,
  output logic [LIVES_W-1:0]           lives,
  output logic                         game_over
);

  localparam int IDX_W = $clog2(NUM_LANES);

  state_e                              state_q, state_d;
  logic [SCORE_W-1:0]                  score_q, score_d;
  logic [LIVES_W-1:0]                  lives_q, lives_d;
  logic [NUM_LANES-1:0]                active_q, active_d;
  logic [NUM_LANES-1:0][POS_W-1:0]     pos_q, pos_d;
  logic [NUM_LANES-1:0][CHAR_W-1:0]    char_q, char_d;
  logic [NUM_LANES-1:0][SPEED_W-1:0]   speed_q, speed_d;
  logic                                rd_active_q, rd_active_d;
  logic [CHAR_W-1:0]                   rd_char_q, rd_char_d;
  logic [POS_W-1:0]                    rd_pos_q, rd_pos_d;

  logic                                in_play, do_spawn;
  logic [NUM_LANES-1:0]                key_cand, lane_lost;
  logic [NUM_LANES-1:0][POS_W:0]       adv;
  logic [NUM_LANES-1:0][POS_W-1:0]     zero_pos;
  logic                                key_hit, free_found;
  logic [IDX_W-1:0]                    key_idx, free_idx;
  logic [6:0]                          lost_cnt;

  assign in_play  = (state_q == ST_PLAY);
  assign zero_pos = '0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign key_cand[i]  = key_valid && in_play && active_q[i] && (char_q[i] == key_code);
    // One extra bit so a wrap past POS_W is seen as a loss, not a small pos.
    assign adv[i]       = {1'b0, pos_q[i]} + (POS_W+1)'(speed_q[i]);
    assign lane_lost[i] = (32'(adv[i]) >= LOWER_BOUND) || adv[i][POS_W];
  end

  lane_select #(.N(NUM_LANES), .POS_W(POS_W)) u_key_sel (
    .cand(key_cand), .pos(pos_q), .idx(key_idx), .found(key_hit)
  );

  // All-zero positions reduce the selector to lowest-index-first.
  lane_select #(.N(NUM_LANES), .POS_W(POS_W)) u_free_sel (
    .cand(~active_q), .pos(zero_pos), .idx(free_idx), .found(free_found)
  );

  assign spawn_ready = in_play && free_found;
  assign do_spawn    = spawn_valid && spawn_ready;

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    lives_d  = lives_q;
    active_d = active_q;
    pos_d    = pos_q;
    char_d   = char_q;
    speed_d  = speed_q;
    lost_cnt = '0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_PLAY;
        active_d = '0;
        pos_d    = '0;
        score_d  = '0;
        lives_d  = LIVES_W'(LIVES);
      end
      ST_PLAY: begin
        if (key_hit) begin
          active_d[key_idx] = 1'b0;
          if (score_q != '1) score_d = score_q + 1'b1;
        end
        if (tick) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (active_q[i] && !(key_hit && key_idx == IDX_W'(i))) begin
              pos_d[i] = adv[i][POS_W-1:0];
              if (lane_lost[i]) begin
                active_d[i] = 1'b0;
                lost_cnt    = lost_cnt + 7'd1;
              end
            end
          end
        end
        if (7'(lives_q) <= lost_cnt) lives_d = '0;
        else                         lives_d = lives_q - lost_cnt[LIVES_W-1:0];
        if (do_spawn) begin
          active_d[free_idx] = 1'b1;
          pos_d[free_idx]    = '0;
          char_d[free_idx]   = spawn_char;
          speed_d[free_idx]  = (spawn_speed == '0) ? SPEED_W'(1) : spawn_speed;
        end
        if (lives_d == '0) state_d = ST_OVER;
      end
      ST_OVER: if (start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_active_d = 1'b0;
    rd_char_d   = '0;
    rd_pos_d    = '0;
    if (32'(rd_lane) < NUM_LANES) begin
      rd_active_d = active_q[rd_lane];
      rd_char_d   = char_q[rd_lane];
      rd_pos_d    = pos_q[rd_lane];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      lives_q     <= '0;
      active_q    <= '0;
      pos_q       <= '0;
      char_q      <= '0;
      speed_q     <= '0;
      rd_active_q <= 1'b0;
      rd_char_q   <= '0;
      rd_pos_q    <= '0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      active_q    <= active_d;
      pos_q       <= pos_d;
      char_q      <= char_d;
      speed_q     <= speed_d;
      rd_active_q <= rd_active_d;
      rd_char_q   <= rd_char_d;
      rd_pos_q    <= rd_pos_d;
    end
  end

  assign state     = state_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign game_over = (state_q == ST_OVER);
  assign rd_active = rd_active_q;
  assign rd_char   = rd_char_q;
  assign rd_pos    = rd_pos_q;

endmodule

// File: tb/tb_char_lane_engine.sv
// Bench for char_lane_engine: directed scenarios plus randomized play against a game-rule model.
module tb_char_lane_engine;

  localparam int NL = 8;
  localparam int LB = 480;
  localparam int LV = 3;

  logic       clk = 1'b0;
  logic       rst_n, start, tick, spawn_valid, spawn_ready, key_valid;
  logic [7:0] spawn_char, key_code, rd_char;
  logic [2:0] spawn_speed, rd_lane;
  logic       rd_active, game_over;
  logic [9:0] rd_pos;
  logic [1:0] state;
  logic [7:0] score;
  logic [3:0] lives;

  char_lane_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_char(spawn_char), .spawn_speed(spawn_speed),
    .key_valid(key_valid), .key_code(key_code),
    .rd_lane(rd_lane), .rd_active(rd_active), .rd_char(rd_char), .rd_pos(rd_pos),
    .state(state), .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Game-rule model: 0=IDLE 1=PLAY 2=OVER
  int m_state, m_score, m_lives;
  bit m_act[NL];
  int m_pos[NL], m_chr[NL], m_spd[NL];
  bit e_ra;
  int e_rc, e_rp;

  function automatic int m_free();
    for (int i = 0; i < NL; i++) if (!m_act[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = 0;
    for (int i = 0; i < NL; i++) begin
      m_act[i] = 0; m_pos[i] = 0; m_chr[i] = 0; m_spd[i] = 0;
    end
  endtask

  task automatic model_step(input bit st, input bit tk, input bit sv, input int sc,
                            input int ss, input bit kv, input int kc);
    int fr, k, lost;
    fr = m_free();
    case (m_state)
      0: if (st) begin
        for (int i = 0; i < NL; i++) begin m_act[i] = 0; m_pos[i] = 0; end
        m_state = 1; m_score = 0; m_lives = LV;
      end
      1: begin
        k = -1;
        if (kv)
          for (int i = 0; i < NL; i++)
            if (m_act[i] && m_chr[i] == kc && (k < 0 || m_pos[i] > m_pos[k])) k = i;
        if (k >= 0) begin
          m_act[k] = 0;
          if (m_score < 255) m_score++;
        end
        if (tk) begin
          lost = 0;
          for (int i = 0; i < NL; i++) if (m_act[i]) begin
            m_pos[i] += m_spd[i];
            if (m_pos[i] >= LB || m_pos[i] >= 1024) begin m_act[i] = 0; lost++; end
            m_pos[i] = m_pos[i] % 1024;
          end
          m_lives = (m_lives > lost) ? m_lives - lost : 0;
        end
        if (sv && fr >= 0) begin
          m_act[fr] = 1; m_pos[fr] = 0; m_chr[fr] = sc; m_spd[fr] = (ss == 0) ? 1 : ss;
        end
        if (m_lives == 0) m_state = 2;
      end
      default: if (st) m_state = 0;
    endcase
  endtask

  // One clock with the given pulses; rd expectation is the pre-edge lane state.
  task automatic drive(input bit st, input bit tk, input bit sv, input int sc, input int ss,
                       input bit kv, input int kc, input int rl);
    start = st; tick = tk; spawn_valid = sv; spawn_char = 8'(sc); spawn_speed = 3'(ss);
    key_valid = kv; key_code = 8'(kc); rd_lane = 3'(rl);
    e_ra = m_act[rl]; e_rc = m_chr[rl]; e_rp = m_pos[rl];
    model_step(st, tk, sv, sc, ss, kv, kc);
    @(posedge clk); #1;
    start = 0; tick = 0; spawn_valid = 0; key_valid = 0;
  endtask

  task automatic idle(input int rl);
    drive(0, 0, 0, 0, 0, 0, 0, rl);
  endtask

  task automatic drive_rst(input bit tk, input bit kv, input int kc);
    rst_n = 0; start = 1; tick = tk; key_valid = kv; key_code = 8'(kc);
    spawn_valid = 1; spawn_char = 8'h41; spawn_speed = 3'd1; rd_lane = 3'd0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1; start = 0; tick = 0; key_valid = 0; spawn_valid = 0;
  endtask

  task automatic test_reset();
    drive_rst(1, 1, 8'h41);
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
    n_vec++; if (score !== 8'd0) begin n_err++; $display("FAIL reset_score got %0d exp 0", score); end
    n_vec++; if (lives !== 4'd0) begin n_err++; $display("FAIL reset_lives got %0d exp 0", lives); end
    n_vec++; if (spawn_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", spawn_ready); end
    n_vec++; if (game_over !== 1'b0) begin n_err++; $display("FAIL reset_over got %b exp 0", game_over); end
    n_vec++; if ({rd_active, rd_char, rd_pos} !== 19'd0) begin n_err++;
      $display("FAIL reset_rd got %b/%0d/%0d exp 0/0/0", rd_active, rd_char, rd_pos); end
  endtask

  task automatic test_start();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL start_state got %0d exp 1", state); end
    n_vec++; if (lives !== 4'(LV)) begin n_err++; $display("FAIL start_lives got %0d exp %0d", lives, LV); end
    n_vec++; if (score !== 8'd0) begin n_err++; $display("FAIL start_score got %0d exp 0", score); end
    n_vec++; if (spawn_ready !== 1'b1) begin n_err++; $display("FAIL start_ready got %b exp 1", spawn_ready); end
  endtask

  task automatic test_fall();
    drive(0, 0, 1, 8'h41, 4, 0, 0, 0);
    for (int t = 0; t < 119; t++) drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(0);
    n_vec++; if (rd_active !== 1'b1 || rd_pos !== 10'd476 || rd_char !== 8'h41) begin n_err++;
      $display("FAIL fall_476 got %b/%0d/%h exp 1/476/41", rd_active, rd_pos, rd_char); end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    n_vec++; if (lives !== 4'd2 || state !== 2'd1) begin n_err++;
      $display("FAIL fall_lost lives=%0d state=%0d exp 2/1", lives, state); end
    idle(0);
    n_vec++; if (rd_active !== 1'b0) begin n_err++; $display("FAIL fall_freed got %b exp 0", rd_active); end
  endtask

  task automatic test_key();
    drive(0, 0, 1, 8'h42, 1, 0, 0, 0);
    drive(0, 0, 1, 8'h42, 2, 0, 0, 0);
    for (int t = 0; t < 3; t++) drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 8'h42, 0);
    n_vec++; if (score !== 8'd1) begin n_err++; $display("FAIL key_score got %0d exp 1", score); end
    idle(0);
    n_vec++; if (rd_active !== 1'b1 || rd_pos !== 10'd3) begin n_err++;
      $display("FAIL key_keep0 got %b/%0d exp 1/3", rd_active, rd_pos); end
    idle(1);
    n_vec++; if (rd_active !== 1'b0) begin n_err++; $display("FAIL key_free1 got %b exp 0", rd_active); end
    drive(0, 0, 0, 0, 0, 1, 8'h5A, 0);
    idle(0);
    n_vec++; if (score !== 8'd1 || lives !== 4'd2 || rd_active !== 1'b1 || rd_pos !== 10'd3) begin n_err++;
      $display("FAIL key_nomatch score=%0d lives=%0d act=%b pos=%0d exp 1/2/1/3", score, lives, rd_active, rd_pos); end
  endtask

  task automatic test_full();
    for (int i = 1; i < NL; i++) drive(0, 0, 1, 8'h43, 1, 0, 0, 0);
    n_vec++; if (spawn_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b exp 0", spawn_ready); end
    drive(0, 0, 1, 8'h45, 5, 1, 8'h42, 0);
    n_vec++; if (spawn_ready !== 1'b1 || score !== 8'd2) begin n_err++;
      $display("FAIL full_keyfree ready=%b score=%0d exp 1/2", spawn_ready, score); end
    drive(0, 0, 1, 8'h45, 5, 0, 0, 0);
    n_vec++; if (spawn_ready !== 1'b0) begin n_err++; $display("FAIL full_refill got %b exp 0", spawn_ready); end
    idle(0);
    n_vec++; if (rd_active !== 1'b1 || rd_char !== 8'h45 || rd_pos !== 10'd0) begin n_err++;
      $display("FAIL full_landed got %b/%h/%0d exp 1/45/0", rd_active, rd_char, rd_pos); end
  endtask

  task automatic test_tie_speed();
    drive_rst(0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 8'h54, 0, 0, 0, 0);
    drive(0, 0, 1, 8'h54, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 8'h54, 0);
    idle(0);
    idle(1);
    n_vec++; if (rd_active !== 1'b1) begin n_err++; $display("FAIL tie_keep1 got %b exp 1", rd_active); end
    idle(0);
    n_vec++; if (rd_active !== 1'b0) begin n_err++; $display("FAIL tie_free0 got %b exp 0", rd_active); end
    drive(0, 0, 1, 8'h55, 0, 0, 0, 0);
    drive(0, 1, 1, 8'h56, 7, 0, 0, 0);
    idle(0);
    n_vec++; if (rd_pos !== 10'd1 || rd_active !== 1'b1) begin n_err++;
      $display("FAIL speed0 got %b/%0d exp 1/1", rd_active, rd_pos); end
    idle(2);
    n_vec++; if (rd_active !== 1'b1 || rd_pos !== 10'd0) begin n_err++;
      $display("FAIL spawn_on_tick got %b/%0d exp 1/0", rd_active, rd_pos); end
    drive(0, 1, 0, 0, 0, 1, 8'h55, 0);
    idle(1);
    n_vec++; if (lives !== 4'(LV) || score !== 8'd2 || rd_pos !== 10'd6) begin n_err++;
      $display("FAIL key_with_tick lives=%0d score=%0d pos1=%0d exp 3/2/6", lives, score, rd_pos); end
  endtask

  task automatic test_over();
    drive_rst(0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 8'h50, 4, 0, 0, 0);
    drive(0, 0, 1, 8'h51, 4, 0, 0, 0);
    for (int t = 0; t < 120; t++) drive(0, 1, 0, 0, 0, 0, 0, 0);
    n_vec++; if (lives !== 4'd1 || state !== 2'd1) begin n_err++;
      $display("FAIL over_twolost lives=%0d state=%0d exp 1/1", lives, state); end
    drive(0, 0, 1, 8'h52, 2, 0, 0, 0);
    drive(0, 0, 1, 8'h53, 2, 0, 0, 0);
    for (int t = 0; t < 239; t++) drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    n_vec++; if (rd_pos !== 10'd478) begin n_err++; $display("FAIL over_478 got %0d exp 478", rd_pos); end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    n_vec++; if (lives !== 4'd0 || state !== 2'd2 || game_over !== 1'b1 || spawn_ready !== 1'b0) begin n_err++;
      $display("FAIL over_enter lives=%0d state=%0d go=%b rdy=%b exp 0/2/1/0", lives, state, game_over, spawn_ready); end
    drive(0, 1, 1, 8'h52, 1, 1, 8'h52, 0);
    n_vec++; if (state !== 2'd2 || lives !== 4'd0 || score !== 8'd0) begin n_err++;
      $display("FAIL over_hold state=%0d lives=%0d score=%0d exp 2/0/0", state, lives, score); end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (state !== 2'd0 || game_over !== 1'b0) begin n_err++;
      $display("FAIL over_idle state=%0d go=%b exp 0/0", state, game_over); end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (state !== 2'd1 || lives !== 4'(LV) || score !== 8'd0) begin n_err++;
      $display("FAIL over_replay state=%0d lives=%0d score=%0d exp 1/3/0", state, lives, score); end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 8'h4D, 3, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive_rst(1, 1, 8'h4D);
    n_vec++; if ({state, score, lives, spawn_ready, game_over} !== 16'd0) begin n_err++;
      $display("FAIL midreset st=%0d sc=%0d lv=%0d rdy=%b go=%b exp all 0", state, score, lives, spawn_ready, game_over); end
    n_vec++; if ({rd_active, rd_char, rd_pos} !== 19'd0) begin n_err++;
      $display("FAIL midreset_rd got %b/%0d/%0d exp 0/0/0", rd_active, rd_char, rd_pos); end
    idle(0);
    n_vec++; if (rd_active !== 1'b0) begin n_err++; $display("FAIL midreset_lane got %b exp 0", rd_active); end
  endtask

  task automatic test_random();
    bit st, tk, sv, kv;
    int sc, ss, kc, rl;
    drive_rst(0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      n_vec++; if (spawn_ready !== ((m_state == 1) && (m_free() >= 0))) begin n_err++;
        $display("FAIL rnd_ready cyc=%0d got %b exp %b", c, spawn_ready, (m_state == 1) && (m_free() >= 0)); end
      st = ($urandom_range(0, 19) == 0);
      tk = $urandom_range(0, 1);
      sv = $urandom_range(0, 1);
      sc = 8'h41 + $urandom_range(0, 3);
      ss = $urandom_range(0, 7);
      kv = ($urandom_range(0, 2) == 0);
      kc = 8'h41 + $urandom_range(0, 3);
      rl = $urandom_range(0, NL - 1);
      drive(st, tk, sv, sc, ss, kv, kc, rl);
      n_vec++; if (state !== 2'(m_state) || score !== 8'(m_score) || lives !== 4'(m_lives) ||
                   game_over !== (m_state == 2)) begin n_err++;
        $display("FAIL rnd_status cyc=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, state, score, lives, m_state, m_score, m_lives); end
      n_vec++; if (rd_active !== e_ra || (e_ra && (rd_char !== 8'(e_rc) || rd_pos !== 10'(e_rp)))) begin n_err++;
        $display("FAIL rnd_rd cyc=%0d lane=%0d got %b/%h/%0d exp %b/%h/%0d", c, rl, rd_active, rd_char, rd_pos, e_ra, e_rc, e_rp); end
    end
  endtask

  initial begin
    rst_n = 0; start = 0; tick = 0; spawn_valid = 0; spawn_char = 0; spawn_speed = 0;
    key_valid = 0; key_code = 0; rd_lane = 0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_start();
    test_fall();
    test_key();
    test_full();
    test_tie_speed();
    test_over();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/char_lane_engine.md
CHAR_LANE_ENGINE -- requirements
Module: char_lane_engine

Interface
REQ-001 SHALL have parameter NUM_LANES, default 8: number of independent falling-character lanes (2..64).
REQ-002 SHALL have parameter POS_W, default 10: vertical position width in pixels.
REQ-003 SHALL have parameter SPEED_W, default 3: per-lane speed width in pixels per tick.
REQ-004 SHALL have parameter LOWER_BOUND, default 480: position at or beyond which a character is lost.
REQ-005 SHALL have parameter LIVES, default 3: lives granted at game start (1..15).
REQ-006 SHALL have port clk, input, 1: single clock, 25 MHz pixel clock domain.
REQ-007 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port start, input, 1: one-cycle pulse that starts a game (IDLE) or returns to IDLE (OVER).
REQ-009 SHALL have port tick, input, 1: one-cycle frame-advance pulse.
REQ-010 SHALL have ports spawn_valid (input, 1), spawn_ready (output, 1), spawn_char (input, 8, ASCII) and spawn_speed (input, SPEED_W): spawn handshake.
REQ-011 SHALL have ports key_valid (input, 1) and key_code (input, 8, ASCII): one-cycle pulse per keypress.
REQ-012 SHALL have ports rd_lane (input, $clog2(NUM_LANES)), rd_active (output, 1), rd_char (output, 8) and rd_pos (output, POS_W): renderer read port.
REQ-013 SHALL have ports state (output, 2), score (output, 8), lives (output, 4) and game_over (output, 1).

Function
REQ-014 States SHALL be IDLE=0, PLAY=1, OVER=2. IDLE->PLAY on start; PLAY->OVER when lives reaches 0; OVER->IDLE on start; no other transitions.
REQ-015 Entering PLAY SHALL clear all lanes (active=0, pos=0), set score=0 and lives=LIVES, in the same cycle the transition is taken.
REQ-016 spawn_ready SHALL be 1 only in PLAY with at least one inactive lane, evaluated on lane state at the start of the cycle.
REQ-017 A spawn (spawn_valid && spawn_ready) SHALL load the lowest-index inactive lane with active=1, pos=0, char=spawn_char and speed=spawn_speed.
REQ-018 A spawn with spawn_speed=0 SHALL be stored as speed 1.
REQ-019 A key (key_valid in PLAY) SHALL free exactly one active lane whose char equals key_code, choosing the largest pos and, on equal pos, the lowest index.
REQ-020 Each key match SHALL increment score by 1, saturating at 255; a key with no match SHALL change nothing.
REQ-021 On tick in PLAY, every active lane not freed by a key in the same cycle SHALL advance pos by speed, computed POS_W+1 bits wide.
REQ-022 A lane whose advanced pos is >= LOWER_BOUND, or overflows POS_W, SHALL be freed, with lives decremented once per lost lane (floor 0).
REQ-023 If several lanes are lost on one tick, lives SHALL decrease by their count saturated at 0, and PLAY->OVER SHALL be taken in that cycle if the result is 0.
REQ-024 Same-cycle ordering SHALL be: key match, then tick, then spawn.
REQ-025 A lane spawned on a tick cycle SHALL hold pos=0 and not advance until the next tick.
REQ-026 A key-freed lane SHALL neither advance nor cost a life on that cycle.
REQ-027 Ticks, keys and spawns SHALL be ignored outside PLAY, and score and lives SHALL hold their values in OVER.
REQ-028 The read port SHALL be registered with 1-cycle latency: rd_* reflects lane state after the previous edge's update.
REQ-029 For rd_lane >= NUM_LANES the read port SHALL return rd_active=0, rd_char=0 and rd_pos=0.
REQ-030 game_over SHALL equal (state==OVER).

Reset
REQ-031 When rst_n=0 at a clk edge, the block SHALL enter IDLE with all lanes inactive, pos=0, char=0, speed=0, score=0, lives=0, spawn_ready=0, game_over=0 and rd_* =0.
REQ-032 Reset SHALL take priority over start, tick, key and spawn in the same cycle, including mid-game.

Structure
REQ-033 State encodings, ASCII width (8) and default parameter values SHALL live in shared package game_pkg.
REQ-034 Match/free-lane selection SHALL be one sub-module, lane_select: a parametrised priority selector that takes per-lane candidate flags and positions and returns the chosen index plus a found flag.
REQ-035 Lane state SHALL be flop arrays (NUM_LANES small); no RAM inference required.

Verification
REQ-036 Reset then start -> state=PLAY, lives=3, score=0, spawn_ready=1 next cycle.
REQ-037 Spawn 'A' speed 4 to lane 0, then 120 ticks -> pos reaches 480 on the 120th tick, lane freed, lives=2.
REQ-038 Spawn 'B' to lanes 0 and 1; give lane 1 a 3-tick lead; key 'B' -> lane 1 freed, lane 0 kept, score=1; key 'Z' -> no change.
REQ-039 Fill all 8 lanes -> spawn_ready=0; key match and spawn_valid in the same cycle -> spawn_ready stays 0 that cycle, then the spawn lands in the freed lane on the following cycle.
REQ-040 lives=1 with two lanes at pos 478 speed 2; tick -> both freed, lives=0, state=OVER; start -> IDLE; start -> PLAY, lives=3.
REQ-041 Assert rst_n=0 mid-PLAY together with tick and key_valid -> all outputs at reset values the next cycle.
